div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 24 ++
 rtl/div_unit.sv | 148 ++++++++++++++
 tb/tb_div_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle RISC-V M-extension divider.
// The optional early-out path is enabled by defining DIV_EARLY_OUT_EN.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Counter must hold the value width itself, hence width+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration: shift the next
// dividend bit into the partial remainder, subtract the divisor if it fits.
module div_step #(
    parameter int n = 32
) (
    input  logic [n:0]   rem_in,
    input  logic [n-1:0] dvd_in,
    input  logic [n-1:0] divisor,
    output logic [n:0]   rem_out,
    output logic [n-1:0] dvd_out
);

    logic [n:0] shifted;
    logic       fits;

    always_comb begin
        shifted = {rem_in[n-1:0], dvd_in[n-1]};
        // rem_in[n] would be the bit shifted past the top; if set the value fits.
        fits    = rem_in[n] || (shifted >= {1'b0, divisor});
        rem_out = fits ? (shifted - {1'b0, divisor}) : shifted;
        dvd_out = {dvd_in[n-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Define DIV_EARLY_OUT_EN to finish |A| < |B| operations at the start edge.
module div_unit
    import div_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         start,
    input  div_op_t      op,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    localparam int           CW       = cnt_width(n);
    localparam logic [n-1:0] MOST_NEG = {1'b1, {(n-1){1'b0}}};

    div_state_t   state_q, state_d;
    logic         is_rem_q, is_rem_d;
    logic         neg_quo_q, neg_quo_d;
    logic         neg_rem_q, neg_rem_d;
    logic [n:0]   rem_q, rem_d;
    logic [n-1:0] dvd_q, dvd_d;
    logic [n-1:0] dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0] result_q, result_d;

    logic [n:0]   step_rem;
    logic [n-1:0] step_dvd;

    logic         is_signed, sign_a, sign_b;
    logic [n-1:0] mag_a, mag_b;
    logic         special;
    logic [n-1:0] special_res;
    logic [n-1:0] quo_fix, rem_fix;

    div_step #(.n(n)) u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .dvd_out (step_dvd)
    );

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        is_signed = ~op[0];
        sign_a    = is_signed & A[n-1];
        sign_b    = is_signed & B[n-1];
        mag_a     = sign_a ? ('0 - A) : A;
        mag_b     = sign_b ? ('0 - B) : B;

        // Cases settled at the start edge without iterating.
        special     = 1'b0;
        special_res = '0;
        if (B == '0) begin
            special     = 1'b1;
            special_res = op[1] ? A : '1;
        end else if (is_signed && (A == MOST_NEG) && (B == '1)) begin
            special     = 1'b1;
            special_res = op[1] ? '0 : A;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (mag_a < mag_b) begin
            special     = 1'b1;
            special_res = op[1] ? A : '0;
        end
`endif

        quo_fix = neg_quo_q ? ('0 - dvd_q) : dvd_q;
        rem_fix = neg_rem_q ? ('0 - rem_q[n-1:0]) : rem_q[n-1:0];

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    is_rem_d  = op[1];
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    rem_d     = '0;
                    dvd_d     = mag_a;
                    dsr_d     = mag_b;
                    cnt_d     = CW'(n);
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit (n=32): results, done latency and
// busy duration are queued at issue time and checked when done appears.
module tb_div_unit;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int N        = 32;
    localparam int FULL_LAT = N + 1;

    logic          clock;
    logic          nReset;
    logic          start;
    div_op_t       op;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int            cyc;
    int            checks;
    int            failures;
    int            busy_cnt;
    int            vec_id;

    logic [N-1:0]  exp_q[$];
    int            cyc_q[$];
    int            busy_q[$];
    string         name_q[$];

    div_unit #(.n(N)) dut (
        .clock  (clock),
        .nReset (nReset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flush_sb();
        exp_q.delete();
        cyc_q.delete();
        busy_q.delete();
        name_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    task automatic monitor();
        logic [N-1:0] e;
        int           ec;
        int           eb;
        string        nm;
        forever begin
            @(negedge clock);
            if (!nReset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done result=%h cyc=%0d", result, cyc);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        eb = busy_q.pop_front();
                        nm = name_q.pop_front();
                        chk({nm, "_result"}, result, e);
                        chk({nm, "_done_cycle"}, N'(cyc), N'(ec));
                        chk({nm, "_busy_cycles"}, N'(busy_cnt), N'(eb));
                    end
                    busy_cnt = 0;
                end
            end
        end
    endtask

    // Driver: present one start for a cycle and queue its expectation.
    task automatic issue(input div_op_t o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] e, input bit fast, input bit now);
        if (!now) @(negedge clock);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        vec_id++;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1 + (fast ? 0 : FULL_LAT));
        busy_q.push_back(fast ? 0 : FULL_LAT);
        name_q.push_back($sformatf("v%0d_%s", vec_id, o.name()));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout pending=%0d expected=0", exp_q.size());
            flush_sb();
        end
    endtask

    task automatic run(input div_op_t o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] e, input bit fast);
        issue(o, a, b, e, fast, 1'b0);
        wait_idle();
    endtask

    initial begin
        int k;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        busy_cnt = 0;
        vec_id   = 0;
        nReset   = 1'b0;
        start    = 1'b0;
        op       = DIV;
        A        = '0;
        B        = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        nReset = 1'b1;
        repeat (2) @(negedge clock);

        // Full-latency arithmetic
        run(DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        run(REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        run(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run(DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run(REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0);

        // Divide by zero and signed overflow
        run(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run(REM,  32'd5, 32'd0, 32'd5, 1'b1);
        run(DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run(REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
        run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

        // Dividend magnitude below divisor magnitude
        run(DIVU, 32'd3, 32'd10, 32'd0, EARLY);
        run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY);
        run(REM,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFD, EARLY);

        // start while busy is ignored
        issue(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        op    = DIV;
        A     = 32'd5;
        B     = 32'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // start in the DONE cycle is accepted back-to-back
        issue(DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);
        k = 0;
        while (!done && k < 60) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL b2b_first_done actual=0 expected=1");
        end
        issue(REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
        wait_idle();

        // Reset after the 10th iteration discards the operation
        issue(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        nReset = 1'b0;
        flush_sb();
        #1;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        run(DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        repeat (5) @(negedge clock);
        chk("final_queue_empty", N'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
